// File: rtl/ssd_scan_receiver_pkg.sv
// Shared constants for the seven-segment scan bus monitor.
package ssd_scan_receiver_pkg;

  // Active-low gfedcba segment codes, c[6]=g ... c[0]=a.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low anode patterns {a4,a3,a2,a1}; exactly one digit selected.
  localparam logic [3:0] AN_DIG0 = 4'b1110;
  localparam logic [3:0] AN_DIG1 = 4'b1101;
  localparam logic [3:0] AN_DIG2 = 4'b1011;
  localparam logic [3:0] AN_DIG3 = 4'b0111;
  localparam logic [3:0] AN_IDLE = 4'b1111;

  // One synchronized bus sample.
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } bus_t;

endpackage

// File: rtl/ssd_seg_to_hex.sv
// Seven-segment (active-low gfedcba) to hex nibble decoder.
module ssd_seg_to_hex
  import ssd_scan_receiver_pkg::*;
(
  input  logic [6:0] c,
  output logic [3:0] nibble,
  output logic       invalid
);

  // Unknown patterns, blank included, decode as 0 and are flagged.
  always_comb begin
    nibble  = 4'h0;
    invalid = 1'b0;
    case (c)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/ssd_scan_receiver.sv
// Bus monitor for a 4-digit multiplexed seven-segment display: synchronizes,
// settles, decodes and assembles the displayed 16-bit value.
module ssd_scan_receiver
  import ssd_scan_receiver_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a1,
  input  logic        a2,
  input  logic        a3,
  input  logic        a4,
  input  logic [6:0]  c,
  output logic [15:0] value,
  output logic        value_valid,
  output logic        frame_err,
  output logic        anode_err,
  output logic        timeout
);

  localparam int             IW         = $clog2(TIMEOUT_CYCLES);
  localparam logic [IW-1:0]  IDLE_LIM   = IW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]     SETTLE_SAT = 8'(SETTLE_CYCLES);
  localparam logic [8:0]     EV_TH      = 9'(SETTLE_CYCLES - 1);

  bus_t            sync1_q, sync2_q, prev_q;
  logic [7:0]      cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic [3:0][3:0] dig_q, dig_d;
  logic [3:0]      derr_q, derr_d;
  logic [3:0]      seen_q, seen_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic [15:0]     value_q, value_d;
  logic            ferr_q, ferr_d;
  logic            valid_q, valid_d;
  logic            aerr_q, aerr_d;

  logic       same, evt, complete, tmo, one_low;
  logic [1:0] slot;
  logic [3:0] nib;
  logic       nib_bad;

  ssd_seg_to_hex u_dec (
    .c       (sync2_q.seg),
    .nibble  (nib),
    .invalid (nib_bad)
  );

  // Two-flop synchronizer; resets to the idle bus so release is quiet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {a4, a3, a2, a1, c};
      sync2_q <= sync1_q;
    end
  end

  // Anode decode: which slot is selected, and whether exactly one is.
  always_comb begin
    slot    = 2'd0;
    one_low = 1'b1;
    case (sync2_q.an)
      AN_DIG0: slot = 2'd0;
      AN_DIG1: slot = 2'd1;
      AN_DIG2: slot = 2'd2;
      AN_DIG3: slot = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  // pend_q marks a stable period not yet handled; it starts clear so the
  // idle bus seen at reset release never produces an event.
  assign same     = (sync2_q == prev_q);
  assign evt      = same && pend_q && (({1'b0, cnt_q} + 9'd1) >= EV_TH);
  assign complete = (seen_q == 4'hF);
  assign tmo      = !complete && (seen_q != 4'h0) && (idle_q == IDLE_LIM);

  // Settle filter, slot capture, frame assembly and idle timeout.
  always_comb begin
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    dig_d   = dig_q;
    derr_d  = derr_q;
    seen_d  = seen_q;
    idle_d  = idle_q;
    value_d = value_q;
    ferr_d  = ferr_q;
    valid_d = 1'b0;
    aerr_d  = 1'b0;

    if (!same) begin
      cnt_d  = 8'd0;
      pend_d = 1'b1;
    end else if (cnt_q != SETTLE_SAT) begin
      cnt_d = cnt_q + 8'd1;
    end

    if (complete) begin
      value_d = dig_q;
      ferr_d  = |derr_q;
      valid_d = 1'b1;
      seen_d  = 4'h0;
    end else if (tmo) begin
      seen_d = 4'h0;
    end

    // A capture lands after any clear above, so a digit arriving on the
    // timeout cycle starts the next frame instead of being lost.
    if (evt) begin
      pend_d = 1'b0;
      idle_d = '0;
      if (one_low) begin
        dig_d[slot]  = nib;
        derr_d[slot] = nib_bad;
        seen_d[slot] = 1'b1;
      end else begin
        aerr_d = 1'b1;
      end
    end else if (tmo) begin
      idle_d = '0;
    end else if (idle_q != IDLE_LIM) begin
      idle_d = idle_q + IW'(1);
    end
  end

  // State register for the filter, slots and outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q  <= '1;
      cnt_q   <= 8'd0;
      pend_q  <= 1'b0;
      dig_q   <= '0;
      derr_q  <= 4'h0;
      seen_q  <= 4'h0;
      idle_q  <= '0;
      value_q <= 16'h0000;
      ferr_q  <= 1'b0;
      valid_q <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      dig_q   <= dig_d;
      derr_q  <= derr_d;
      seen_q  <= seen_d;
      idle_q  <= idle_d;
      value_q <= value_d;
      ferr_q  <= ferr_d;
      valid_q <= valid_d;
      aerr_q  <= aerr_d;
    end
  end

  assign value       = value_q;
  assign value_valid = valid_q;
  assign frame_err   = ferr_q;
  assign anode_err   = aerr_q;
  assign timeout     = tmo;

endmodule
